// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: forwarding, load-use stalls,
// redirect flushes and a timer-interrupt drain/trap sequencer. Define HAZARD_PERF_CNT_EN for stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rs1_id,
    input  logic [REG_AW-1:0] rs2_id,
    input  logic [REG_AW-1:0] rs1_ex,
    input  logic [REG_AW-1:0] rs2_ex,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              rf_en_ex,
    input  logic              rd_en_ex,
    input  logic [REG_AW-1:0] rd_mem,
    input  logic              rf_en_mem,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              rf_en_wb,
    input  logic              br_take_id,
    input  logic              br_taken_ex,
    input  logic              epc_taken_mem,
    input  logic              timer_interrupt,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall_if,
    output logic              stall_id,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              trap_req,
    output logic [1:0]        hz_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_TRAP  = 2'b10,
        ST_WAIT  = 2'b11
    } state_t;

    localparam logic [3:0] DRAIN_INIT = 4'(DRAIN_CYCLES - 1);
    localparam logic [3:0] WAIT_INIT  = 4'd3;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       irq_pending, irq_pending_nxt;
    logic       load_use, lu_hit, busy;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (rf_en_mem && (rd_mem != '0) && (rd_mem == rs))
            return 2'b01;
        else if (rf_en_wb && (rd_wb != '0) && (rd_wb == rs))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            irq_pending <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            irq_pending <= irq_pending_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        irq_pending_nxt = irq_pending;
        fwd_a_sel       = 2'b00;
        fwd_b_sel       = 2'b00;
        stall_if        = 1'b0;
        stall_id        = 1'b0;
        flush_id        = 1'b0;
        flush_ex        = 1'b0;
        flush_mem       = 1'b0;
        trap_req        = 1'b0;
        hz_state        = 2'b00;

        case (state)
            ST_RUN: begin
                // A CSR redirect in the accept cycle defers the interrupt by one cycle.
                if (timer_interrupt || irq_pending) begin
                    if (epc_taken_mem) begin
                        irq_pending_nxt = 1'b1;
                    end else begin
                        state_nxt       = ST_DRAIN;
                        cnt_nxt         = DRAIN_INIT;
                        irq_pending_nxt = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (epc_taken_mem)
                    cnt_nxt = DRAIN_INIT;
                else if (cnt == '0)
                    state_nxt = ST_TRAP;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            ST_TRAP: begin
                state_nxt = ST_WAIT;
                cnt_nxt   = WAIT_INIT;
            end
            ST_WAIT: begin
                if (epc_taken_mem || (cnt == '0))
                    state_nxt = ST_RUN;
                else
                    cnt_nxt = cnt - 4'd1;
            end
            default: state_nxt = ST_RUN;
        endcase

        busy     = (state != ST_RUN);
        load_use = rd_en_ex && rf_en_ex && (rd_ex != '0) &&
                   ((rd_ex == rs1_id) || (rd_ex == rs2_id));
        lu_hit   = load_use && !epc_taken_mem && !br_taken_ex && !br_take_id;

        // Outputs are forced quiet while reset is held.
        if (rst) begin
            fwd_a_sel = fwd_sel(rs1_ex);
            fwd_b_sel = fwd_sel(rs2_ex);
            stall_if  = lu_hit || busy;
            stall_id  = lu_hit;
            flush_id  = epc_taken_mem || br_taken_ex || br_take_id || busy;
            flush_ex  = epc_taken_mem || br_taken_ex || lu_hit;
            flush_mem = epc_taken_mem;
            trap_req  = (state == ST_TRAP);
            hz_state  = state;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if && (stall_cnt != 32'hFFFF_FFFF))
                stall_cnt <= stall_cnt + 32'd1;
            if ((flush_id || flush_ex || flush_mem) && (flush_cnt != 32'hFFFF_FFFF))
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule
